// File: rtl/qs_fifo_drain.sv
// Pop-side drain engine for qs_fifo: pops head words into a 2-entry skid buffer
// and presents them on a registered valid/ready stream, with flush and a delivery counter.
module qs_fifo_drain #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable_i,
    input  logic              flush_i,
    input  logic              fifo_empty_i,
    input  logic [DATA_W-1:0] fifo_pop_data_i,
    output logic              fifo_pop_o,
    output logic              out_valid_o,
    output logic [DATA_W-1:0] out_data_o,
    input  logic              out_ready_i,
    output logic [CNT_W-1:0]  count_o,
    output logic              busy_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_FLUSH  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        occ_q, occ_d;
    logic [DATA_W-1:0] head_q, head_d;
    logic [DATA_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              busy_q, busy_d;
    logic              push;
    logic              pull;

    // In FLUSH the pop is not gated by occupancy because popped words are dropped.
    always_comb begin
        fifo_pop_o = 1'b0;
        case (state_q)
            ST_STREAM: fifo_pop_o = !fifo_empty_i && (occ_q < 2'd2);
            ST_FLUSH:  fifo_pop_o = !fifo_empty_i;
            default:   fifo_pop_o = 1'b0;
        endcase
    end

    assign push        = fifo_pop_o && (state_q == ST_STREAM);
    assign out_valid_o = (occ_q != 2'd0);
    assign pull        = out_valid_o && out_ready_i;
    assign out_data_o  = head_q;
    assign count_o     = count_q;
    assign busy_o      = busy_q;

    always_comb begin
        state_d = state_q;
        occ_d   = occ_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_i) begin
            // Flush wins over everything, including a transfer completing this cycle.
            state_d = ST_FLUSH;
            occ_d   = 2'd0;
        end else begin
            case (state_q)
                ST_IDLE:   if (enable_i) state_d = ST_STREAM;
                ST_STREAM: if (!enable_i) state_d = ST_IDLE;
                ST_FLUSH:  if (fifo_empty_i) state_d = enable_i ? ST_STREAM : ST_IDLE;
                default:   state_d = ST_IDLE;
            endcase
            if (pull) count_d = count_q + CNT_W'(1);
            case ({push, pull})
                2'b10: begin
                    if (occ_q == 2'd0) head_d = fifo_pop_data_i;
                    else               tail_d = fifo_pop_data_i;
                    occ_d = occ_q + 2'd1;
                end
                2'b01: begin
                    head_d = tail_q;
                    occ_d  = occ_q - 2'd1;
                end
                2'b11:   head_d = fifo_pop_data_i;
                default: ;
            endcase
        end
        busy_d = (state_d == ST_FLUSH) || (occ_d != 2'd0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            occ_q   <= 2'd0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            occ_q   <= occ_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            busy_q  <= busy_d;
        end
    end

endmodule

// File: tb/tb_qs_fifo_drain.sv
// Bench for qs_fifo_drain: a queue-based model of the FIFO, skid buffer and counter,
// checked every cycle, plus directed scenarios with literal expectations.
module tb_qs_fifo_drain;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       enable_i = 1'b0;
    logic       flush_i = 1'b0;
    logic       fifo_empty_i = 1'b1;
    logic [7:0] fifo_pop_data_i = 8'h00;
    logic       out_ready_i = 1'b0;
    logic       fifo_pop_o, out_valid_o, busy_o;
    logic [7:0] out_data_o;
    logic [15:0] count_o;
    logic       pop2, valid2, busy2;
    logic [7:0] data2;
    logic [1:0] count2;

    qs_fifo_drain #(.DATA_W(8), .CNT_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .enable_i(enable_i), .flush_i(flush_i),
        .fifo_empty_i(fifo_empty_i), .fifo_pop_data_i(fifo_pop_data_i),
        .fifo_pop_o(fifo_pop_o), .out_valid_o(out_valid_o), .out_data_o(out_data_o),
        .out_ready_i(out_ready_i), .count_o(count_o), .busy_o(busy_o)
    );

    qs_fifo_drain #(.DATA_W(8), .CNT_W(2)) dut_small (
        .clk(clk), .reset_n(reset_n), .enable_i(enable_i), .flush_i(flush_i),
        .fifo_empty_i(fifo_empty_i), .fifo_pop_data_i(fifo_pop_data_i),
        .fifo_pop_o(pop2), .out_valid_o(valid2), .out_data_o(data2),
        .out_ready_i(out_ready_i), .count_o(count2), .busy_o(busy2)
    );

    always #5 clk = ~clk;

    typedef enum {M_IDLE, M_STREAM, M_FLUSH} mode_e;
    mode_e       m_mode = M_IDLE;
    logic [7:0]  fifo_q[$];
    logic [7:0]  skid[$];
    logic [7:0]  seen[$];
    logic [1:0]  cnt2_log[$];
    logic [1:0]  last_cnt2 = 2'd0;
    int unsigned m_count = 0;
    bit          m_busy = 1'b0;
    bit          dut_pop;
    int          npops = 0;
    int          total = 0;
    int          bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit exp_pop();
        case (m_mode)
            M_STREAM: return (fifo_q.size() != 0) && (skid.size() < 2);
            M_FLUSH:  return fifo_q.size() != 0;
            default:  return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE;
        skid.delete();
        m_count = 0;
        m_busy = 1'b0;
    endtask

    // Called at the rising edge, before the bench FIFO is popped.
    task automatic model_step();
        bit p, x, push;
        logic [7:0] w;
        p = exp_pop();
        x = (skid.size() != 0) && out_ready_i;
        push = p && (m_mode == M_STREAM);
        w = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
        if (flush_i) begin
            skid.delete();
            m_mode = M_FLUSH;
        end else begin
            if (x) begin
                void'(skid.pop_front());
                m_count++;
            end
            if (push) skid.push_back(w);
            case (m_mode)
                M_IDLE:   if (enable_i) m_mode = M_STREAM;
                M_STREAM: if (!enable_i) m_mode = M_IDLE;
                default:  if (fifo_q.size() == 0) m_mode = enable_i ? M_STREAM : M_IDLE;
            endcase
        end
        m_busy = (m_mode == M_FLUSH) || (skid.size() != 0);
    endtask

    task automatic compare_outputs();
        chk("valid", out_valid_o, skid.size() != 0);
        chk("valid_small", valid2, skid.size() != 0);
        if (skid.size() != 0) begin
            chk("data", out_data_o, skid[0]);
            chk("data_small", data2, skid[0]);
        end
        chk("count", count_o, m_count % 65536);
        chk("count_small", count2, m_count % 4);
        chk("busy", busy_o, m_busy);
        chk("busy_small", busy2, m_busy);
        chk("pop", fifo_pop_o, exp_pop());
        chk("pop_small", pop2, exp_pop());
    endtask

    task automatic cyc(input bit en, input bit fl, input bit rdy);
        @(negedge clk);
        enable_i = en;
        flush_i = fl;
        out_ready_i = rdy;
        fifo_empty_i = (fifo_q.size() == 0);
        fifo_pop_data_i = fifo_empty_i ? 8'h00 : fifo_q[0];
        #1;
        compare_outputs();
        if (out_valid_o && out_ready_i && !flush_i) seen.push_back(out_data_o);
        if (count2 != last_cnt2) begin
            cnt2_log.push_back(count2);
            last_cnt2 = count2;
        end
        dut_pop = fifo_pop_o;
        @(posedge clk);
        model_step();
        if (dut_pop && fifo_q.size() != 0) begin
            void'(fifo_q.pop_front());
            npops++;
        end
        #2;
    endtask

    initial begin
        // Reset: pops must stay low even with a loaded FIFO and enable high.
        fifo_q.push_back(8'hAB);
        fifo_q.push_back(8'hCC);
        @(negedge clk);
        enable_i = 1'b1;
        out_ready_i = 1'b1;
        fifo_empty_i = 1'b0;
        fifo_pop_data_i = 8'hAB;
        #1;
        chk("rst_valid", out_valid_o, 1'b0);
        chk("rst_data", out_data_o, 8'h00);
        chk("rst_count", count_o, 16'h0000);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_pop", fifo_pop_o, 1'b0);
        model_reset();
        enable_i = 1'b0;
        out_ready_i = 1'b0;
        reset_n = 1'b1;

        // Free-running delivery of AB, CC.
        repeat (5) cyc(1, 0, 1);
        chk("t1_n", seen.size(), 2);
        chk("t1_w0", seen[0], 8'hAB);
        chk("t1_w1", seen[1], 8'hCC);
        chk("t1_count", count_o, 16'd2);
        chk("t1_pop_idle", fifo_pop_o, 1'b0);

        // Backpressure: two pops fill the skid, third word stays in the FIFO.
        seen.delete();
        npops = 0;
        fifo_q.push_back(8'h11);
        fifo_q.push_back(8'h22);
        fifo_q.push_back(8'h33);
        repeat (4) cyc(1, 0, 0);
        chk("t2_pops", npops, 2);
        chk("t2_left", fifo_q.size(), 1);
        chk("t2_busy", busy_o, 1'b1);
        repeat (4) cyc(1, 0, 1);
        chk("t2_n", seen.size(), 3);
        chk("t2_w0", seen[0], 8'h11);
        chk("t2_w1", seen[1], 8'h22);
        chk("t2_w2", seen[2], 8'h33);
        chk("t2_count", count_o, 16'd5);

        // Flush with a full skid and one word left in the FIFO.
        seen.delete();
        fifo_q.push_back(8'h41);
        fifo_q.push_back(8'h42);
        fifo_q.push_back(8'h44);
        repeat (3) cyc(1, 0, 0);
        cyc(1, 1, 1);
        chk("t3_valid_drop", out_valid_o, 1'b0);
        chk("t3_busy_flush", busy_o, 1'b1);
        repeat (3) cyc(1, 0, 1);
        chk("t3_fifo_empty", fifo_q.size(), 0);
        chk("t3_count", count_o, 16'd5);
        chk("t3_busy_end", busy_o, 1'b0);
        chk("t3_n", seen.size(), 0);

        // Disable with one word held: it still drains, no new pops.
        seen.delete();
        npops = 0;
        fifo_q.push_back(8'h55);
        cyc(1, 0, 0);
        cyc(0, 0, 0);
        fifo_q.push_back(8'h66);
        repeat (3) cyc(0, 0, 1);
        chk("t4_held", fifo_q.size(), 1);
        chk("t4_pops", npops, 1);
        chk("t4_w0", seen[0], 8'h55);
        repeat (4) cyc(1, 0, 1);
        chk("t4_w1", seen[1], 8'h66);
        chk("t4_count", count_o, 16'd7);

        // Asynchronous reset while a word is presented.
        seen.delete();
        fifo_q.push_back(8'h77);
        fifo_q.push_back(8'h78);
        repeat (2) cyc(1, 0, 0);
        @(negedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk("t5_valid", out_valid_o, 1'b0);
        chk("t5_data", out_data_o, 8'h00);
        chk("t5_count", count_o, 16'h0000);
        chk("t5_busy", busy_o, 1'b0);
        chk("t5_pop", fifo_pop_o, 1'b0);
        model_reset();
        enable_i = 1'b0;
        flush_i = 1'b0;
        out_ready_i = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) cyc(0, 0, 1);
        chk("t5_n", seen.size(), 0);

        // Narrow counter wraps modulo 4.
        cnt2_log.delete();
        last_cnt2 = 2'd0;
        for (int i = 1; i <= 6; i++) fifo_q.push_back(8'(i));
        repeat (10) cyc(1, 0, 1);
        chk("t6_n", cnt2_log.size(), 6);
        chk("t6_c0", cnt2_log[0], 2'd1);
        chk("t6_c1", cnt2_log[1], 2'd2);
        chk("t6_c2", cnt2_log[2], 2'd3);
        chk("t6_c3", cnt2_log[3], 2'd0);
        chk("t6_c4", cnt2_log[4], 2'd1);
        chk("t6_c5", cnt2_log[5], 2'd2);
        chk("t6_count16", count_o, 16'd6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
